morse_key_assembler: RTL and testbench

- Sits directly downstream of the 4x4 keypad scanner and consumes its keyboard_val / key_pressed_flag outputs.
- Turns key presses into Morse symbols: key 1 = dot, key 2 = dash, key E = end of letter, key 0 = word space, key F = clear.
- Collects up to MAX_SYM symbols, decodes them to 8-bit ASCII, and presents each character on a valid/ready output port to the display/text stage.
- Optional auto-commit closes a letter after an idle timeout.

---
 rtl/morse_pkg.sv | 22 ++
 rtl/morse_lut.sv | 54 +++++
 rtl/morse_key_assembler.sv | 170 +++++++++++++++++
 tb/tb_morse_key_assembler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants for the Morse keypad path.
// Key codes, ASCII codes, FSM states and default letter length.
package morse_pkg;

  localparam int MAX_SYM_DEF = 5;

  localparam logic [3:0] KEY_DOT   = 4'h1;
  localparam logic [3:0] KEY_DASH  = 4'h2;
  localparam logic [3:0] KEY_END   = 4'hE;
  localparam logic [3:0] KEY_SPACE = 4'h0;
  localparam logic [3:0] KEY_CLR   = 4'hF;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ERR   = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse decode: (len, pattern) -> ASCII, '?' if unmapped.
// Ports: len = symbol count, pat = symbols right-aligned, first in MSB, 1 = dash.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [4:0] pat,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_ERR;
    case ({len, pat})
      {3'd1, 5'b00000}: ascii = "E";
      {3'd1, 5'b00001}: ascii = "T";
      {3'd2, 5'b00000}: ascii = "I";
      {3'd2, 5'b00001}: ascii = "A";
      {3'd2, 5'b00010}: ascii = "N";
      {3'd2, 5'b00011}: ascii = "M";
      {3'd3, 5'b00000}: ascii = "S";
      {3'd3, 5'b00001}: ascii = "U";
      {3'd3, 5'b00010}: ascii = "R";
      {3'd3, 5'b00011}: ascii = "W";
      {3'd3, 5'b00100}: ascii = "D";
      {3'd3, 5'b00101}: ascii = "K";
      {3'd3, 5'b00110}: ascii = "G";
      {3'd3, 5'b00111}: ascii = "O";
      {3'd4, 5'b00000}: ascii = "H";
      {3'd4, 5'b00001}: ascii = "V";
      {3'd4, 5'b00010}: ascii = "F";
      {3'd4, 5'b00100}: ascii = "L";
      {3'd4, 5'b00110}: ascii = "P";
      {3'd4, 5'b00111}: ascii = "J";
      {3'd4, 5'b01000}: ascii = "B";
      {3'd4, 5'b01001}: ascii = "X";
      {3'd4, 5'b01010}: ascii = "C";
      {3'd4, 5'b01011}: ascii = "Y";
      {3'd4, 5'b01100}: ascii = "Z";
      {3'd4, 5'b01101}: ascii = "Q";
      {3'd5, 5'b11111}: ascii = "0";
      {3'd5, 5'b01111}: ascii = "1";
      {3'd5, 5'b00111}: ascii = "2";
      {3'd5, 5'b00011}: ascii = "3";
      {3'd5, 5'b00001}: ascii = "4";
      {3'd5, 5'b00000}: ascii = "5";
      {3'd5, 5'b10000}: ascii = "6";
      {3'd5, 5'b11000}: ascii = "7";
      {3'd5, 5'b11100}: ascii = "8";
      {3'd5, 5'b11110}: ascii = "9";
      default:          ascii = ASCII_ERR;
    endcase
  end

endmodule

// File: rtl/morse_key_assembler.sv
// Keypad presses -> Morse symbols -> ASCII chars on a valid/ready port.
// Ports: clk, rst (async low), keyboard_val, key_pressed_flag in;
// out_char/out_valid/out_ready, sym_count, overflow, key_dropped.
module morse_key_assembler
  import morse_pkg::*;
#(
  parameter int MAX_SYM            = MAX_SYM_DEF,
  parameter int AUTO_COMMIT_CYCLES = 100_000_000,
  parameter int CNT_W              = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keyboard_val,
  input  logic       key_pressed_flag,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sym_count,
  output logic       overflow,
  output logic       key_dropped
);

  localparam bit AUTO_EN = (AUTO_COMMIT_CYCLES != 0);
  localparam logic [CNT_W-1:0] COMMIT_AT =
    CNT_W'(AUTO_EN ? AUTO_COMMIT_CYCLES - 1 : 0);
  localparam logic [2:0] MAX_CNT = 3'(MAX_SYM);

  logic               sync1;
  logic               sync2;
  logic               sync3;
  logic               key_evt;
  logic [3:0]         key_code;
  logic               k_sym;
  logic               k_end;
  logic               k_spc;
  logic               k_clr;
  logic               is_dash;
  logic               auto_fire;
  logic [MAX_SYM-1:0] sym_pat;
  logic [CNT_W-1:0]   idle_cnt;
  logic [4:0]         lut_pat;
  logic [7:0]         lut_char;
  logic [7:0]         dec_char;
  state_t             state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      key_evt  <= 1'b0;
      key_code <= '0;
    end else begin
      sync1   <= key_pressed_flag;
      sync2   <= sync1;
      sync3   <= sync2;
      key_evt <= sync2 & ~sync3;
      if (sync2 & ~sync3)
        key_code <= keyboard_val;
    end
  end

  always_comb begin
    k_sym = 1'b0;
    k_end = 1'b0;
    k_spc = 1'b0;
    k_clr = 1'b0;
    unique case (1'b1)
      (key_code == KEY_DOT),
      (key_code == KEY_DASH):  k_sym = 1'b1;
      (key_code == KEY_END):   k_end = 1'b1;
      (key_code == KEY_SPACE): k_spc = 1'b1;
      (key_code == KEY_CLR):   k_clr = 1'b1;
      default: ;
    endcase
  end

  assign is_dash = (key_code == KEY_DASH);

  // Bits above sym_count are always zero, so the
  // buffer can feed the LUT without masking.
  assign lut_pat = 5'(sym_pat);

  morse_lut u_lut (
    .len   (sym_count),
    .pat   (lut_pat),
    .ascii (lut_char)
  );

  assign dec_char = overflow ? ASCII_ERR : lut_char;

  assign auto_fire = AUTO_EN
                   && (state == ST_COLLECT)
                   && (idle_cnt == COMMIT_AT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      sym_pat     <= '0;
      sym_count   <= '0;
      overflow    <= 1'b0;
      out_char    <= '0;
      out_valid   <= 1'b0;
      key_dropped <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      key_dropped <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (key_evt) begin
            unique case (1'b1)
              k_sym: begin
                sym_pat   <= {sym_pat[MAX_SYM-2:0], is_dash};
                sym_count <= 3'd1;
                state     <= ST_COLLECT;
              end
              k_spc: begin
                out_char  <= ASCII_SPACE;
                out_valid <= 1'b1;
                state     <= ST_EMIT;
              end
              default: ;
            endcase
          end
        end
        ST_COLLECT: begin
          if (key_evt && k_sym) begin
            idle_cnt <= '0;
            if (sym_count == MAX_CNT) begin
              overflow <= 1'b1;
            end else begin
              sym_pat   <= {sym_pat[MAX_SYM-2:0], is_dash};
              sym_count <= sym_count + 3'd1;
            end
          end else if (key_evt && (k_end || k_spc)) begin
            out_char  <= dec_char;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end else if (key_evt && k_clr) begin
            sym_pat   <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
            state     <= ST_IDLE;
          end else if (auto_fire) begin
            out_char  <= dec_char;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_EMIT: begin
          idle_cnt <= '0;
          if (key_evt && (k_sym || k_end || k_spc || k_clr))
            key_dropped <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            sym_pat   <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_assembler.sv
// Bench for morse_key_assembler: directed steps plus random key
// sequences checked against a string-based Morse reference model.
module tb_morse_key_assembler;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] kv  = 4'h0;
  logic       kf  = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_char;
  logic       out_valid;
  logic [2:0] sym_count;
  logic       overflow;
  logic       key_dropped;

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  string      m_s;
  bit         m_ovf;

  string mtab[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....",
    "--...", "---..", "----."
  };

  always #5 clk = ~clk;

  morse_key_assembler #(
    .MAX_SYM            (5),
    .AUTO_COMMIT_CYCLES (50),
    .CNT_W              (27)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .keyboard_val     (kv),
    .key_pressed_flag (kf),
    .out_char         (out_char),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .sym_count        (sym_count),
    .overflow         (overflow),
    .key_dropped      (key_dropped)
  );

  always @(negedge clk) begin
    if (rst && out_valid && out_ready)
      got.push_back(out_char);
    if (key_dropped)
      drops++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold,
                       input int rel);
    kv = k;
    kf = 1'b1;
    cyc(hold);
    kf = 1'b0;
    cyc(rel);
  endtask

  task automatic expect_char(input string tag, input logic [7:0] c);
    for (int i = 0; i < 40 && got.size() == 0; i++)
      cyc(1);
    chk({tag, "_avail"}, 32'(got.size() != 0), 1);
    if (got.size() != 0)
      chk(tag, 32'(got.pop_front()), 32'(c));
  endtask

  function automatic logic [7:0] ref_dec();
    if (m_ovf)
      return 8'h3F;
    for (int i = 0; i < 36; i++)
      if (mtab[i] == m_s)
        return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
    return 8'h3F;
  endfunction

  task automatic model_key(input logic [3:0] k);
    case (k)
      4'h1, 4'h2: begin
        if (m_s.len() >= 5)
          m_ovf = 1'b1;
        else if (k == 4'h1)
          m_s = {m_s, "."};
        else
          m_s = {m_s, "-"};
      end
      4'hE, 4'h0: begin
        if (m_s.len() > 0) begin
          exp_q.push_back(ref_dec());
          m_s   = "";
          m_ovf = 1'b0;
        end else if (k == 4'h0) begin
          exp_q.push_back(8'h20);
        end
      end
      4'hF: begin
        m_s   = "";
        m_ovf = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    int n;
    int d0;
    int sz;
    int r;
    logic [3:0] k;

    cyc(2);
    chk("rst_char", 32'(out_char), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cnt", 32'(sym_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(key_dropped), 0);
    rst = 1'b1;
    cyc(3);

    // 'A' with latency: first sampling edge of E, out_valid on 4th
    press(KEY_DOT, 10, 10);
    press(KEY_DASH, 10, 10);
    kv = KEY_END;
    kf = 1'b1;
    cyc(3);
    chk("lat_early", 32'(out_valid), 0);
    cyc(1);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_char", 32'(out_char), 32'h41);
    cyc(1);
    chk("lat_1cyc", 32'(out_valid), 0);
    cyc(5);
    kf = 1'b0;
    cyc(10);
    expect_char("A", 8'h41);

    // SOS
    for (int l = 0; l < 3; l++) begin
      k = (l == 1) ? KEY_DASH : KEY_DOT;
      repeat (3) press(k, 10, 10);
      chk("sos_cnt3", 32'(sym_count), 3);
      press(KEY_END, 10, 10);
      chk("sos_cnt0", 32'(sym_count), 0);
    end
    expect_char("sos_s1", 8'h53);
    expect_char("sos_o", 8'h4F);
    expect_char("sos_s2", 8'h53);

    // unmapped key in COLLECT is ignored
    press(KEY_DOT, 10, 10);
    press(4'h7, 10, 10);
    chk("ign_cnt", 32'(sym_count), 1);
    press(KEY_END, 10, 10);
    expect_char("ign_e", 8'h45);

    // overflow
    repeat (5) press(KEY_DOT, 10, 10);
    chk("ovf_pre", 32'(overflow), 0);
    press(KEY_DOT, 10, 10);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_cnt", 32'(sym_count), 5);
    press(KEY_END, 10, 10);
    expect_char("ovf_char", 8'h3F);
    chk("ovf_clr", 32'(overflow), 0);

    // back-pressure and dropped key
    out_ready = 1'b0;
    press(KEY_DOT, 10, 10);
    press(KEY_END, 10, 10);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_char", 32'(out_char), 32'h45);
    d0 = drops;
    press(KEY_DASH, 10, 10);
    chk("bp_drop", 32'(drops - d0), 1);
    chk("bp_hold", 32'(out_char), 32'h45);
    chk("bp_none", 32'(got.size()), 0);
    out_ready = 1'b1;
    cyc(4);
    expect_char("bp_xfer", 8'h45);
    chk("bp_once", 32'(got.size()), 0);
    chk("bp_idle_v", 32'(out_valid), 0);
    press(KEY_END, 10, 10);
    chk("bp_idle_e", 32'(got.size()), 0);

    // auto-commit: accepted at edge 4, committed 50 idle cycles later
    press(KEY_DASH, 10, 10);
    kv = KEY_DOT;
    kf = 1'b1;
    n  = 0;
    while (n < 200 && !out_valid) begin
      cyc(1);
      n++;
      if (n == 10)
        kf = 1'b0;
    end
    kf = 1'b0;
    chk("auto_lat", 32'(n), 54);
    expect_char("auto_n", 8'h4E);
    sz = got.size();
    press(KEY_DASH, 10, 10);
    press(KEY_DOT, 10, 10);
    press(KEY_CLR, 10, 10);
    cyc(60);
    chk("clr_none", 32'(got.size()), 32'(sz));
    chk("clr_cnt", 32'(sym_count), 0);

    // async reset in COLLECT and with a pending char
    repeat (3) press(KEY_DOT, 10, 10);
    chk("ar_cnt3", 32'(sym_count), 3);
    rst = 1'b0;
    #1;
    chk("ar_cnt", 32'(sym_count), 0);
    chk("ar_ovf", 32'(overflow), 0);
    chk("ar_valid", 32'(out_valid), 0);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    out_ready = 1'b0;
    press(KEY_DOT, 10, 10);
    press(KEY_END, 10, 10);
    chk("ar_pend", 32'(out_valid), 1);
    rst = 1'b0;
    #1;
    chk("ar_pv", 32'(out_valid), 0);
    chk("ar_pc", 32'(out_char), 0);
    cyc(1);
    rst = 1'b1;
    out_ready = 1'b1;
    cyc(2);
    press(KEY_DOT, 10, 10);
    press(KEY_END, 10, 10);
    expect_char("ar_e", 8'h45);

    // random key sequences against the reference model
    got.delete();
    exp_q.delete();
    m_s   = "";
    m_ovf = 1'b0;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)
        k = KEY_DOT;
      else if (r < 7)
        k = KEY_DASH;
      else if (r == 7)
        k = KEY_END;
      else if (r == 8)
        k = KEY_SPACE;
      else
        k = KEY_CLR;
      model_key(k);
      press(k, int'($urandom_range(4, 12)), int'($urandom_range(4, 12)));
      chk("rnd_cnt", 32'(sym_count), 32'(m_s.len()));
      chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
    end
    model_key(KEY_END);
    press(KEY_END, 6, 10);
    chk("rnd_n", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk("rnd_char", 32'(got[i]), 32'(exp_q[i]));
    chk("rnd_drop", 32'(drops), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
